axis_packet_writer: RTL
=======================

Name: axis_packet_writer

Overview:
- Upstream stage of the packet RAM. Accepts one 32-bit AXI-Stream packet and packs beats pairwise into 64-bit writes, to even word addresses.
- Clears the RAM length tracker at packet start.
- Hands the completed buffer to the filter core with a ready/ack handshake. Holds off the stream until the filter core releases the buffer.

Parameters:
- PORT_ADDR_WIDTH, 10, word address width of the packet RAM; capacity = 2**PORT_ADDR_WIDTH 32-bit words.
- PORT_DATA_WIDTH, 32, stream beat width and RAM word width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  PORT_DATA_WIDTH  stream beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- s_axis_tlast  in  1  last beat of packet.
- ram_addr  out  PORT_ADDR_WIDTH  write word address; always even.
- ram_di  out  2*PORT_DATA_WIDTH  {word at ram_addr, word at ram_addr+1}.
- ram_wr_en  out  1  one-cycle write strobe.
- ram_len_rst  out  1  one-cycle pulse clearing the RAM length tracker.
- pkt_ready  out  1  complete packet resident in RAM.
- pkt_words  out  PORT_ADDR_WIDTH+1  stored word count; valid while pkt_ready.
- pkt_overflow  out  1  packet was truncated; valid while pkt_ready.
- pkt_ack  in  1  filter core releases the buffer.

Behaviour:
- Reset values: state=IDLE; all outputs 0; word counter 0; hold register 0.
- All outputs are registered.
- FSM states:
  - IDLE: assert ram_len_rst for exactly 1 cycle; tready=0; clear the counter and overflow flag; next state FILL.
  - FILL: tready=1.
    - On an even-position beat (counter even), latch the beat into hold.
    - On an odd-position beat, next cycle: ram_wr_en=1, ram_addr=counter-1, ram_di={hold, beat}.
    - Counter increments per accepted beat.
    - tlast on an odd-position beat: after the write, go to DONE.
    - tlast on an even-position beat: go to FLUSH.
  - FLUSH: tready=0; ram_wr_en=1, ram_addr=counter-1, ram_di={hold, 0}; next state DONE. The zero pad lands in the unused upper slot.
  - DROP: entered when a beat arrives with counter == 2**PORT_ADDR_WIDTH. The beat is discarded; pkt_overflow is set. tready=1; discard beats with no writes. tlast goes to DONE. If the overflowing beat itself has tlast, go straight to DONE.
  - DONE: tready=0; pkt_ready=1. pkt_words = counter, saturated at capacity. On pkt_ack: pkt_ready=0 next cycle; go to IDLE.
- Write latency: the RAM write strobe fires 1 cycle after the accepting handshake of the odd beat.
- Writes are only issued to even addresses, so addr+1 never wraps past capacity.
- The capacity boundary is exact. A packet of exactly 2**PORT_ADDR_WIDTH words is not an overflow: the last write is at 2**PORT_ADDR_WIDTH-2, and pkt_overflow=0.
- tvalid low mid-packet: the FSM holds state; hold and counter are unchanged.
- pkt_ack outside DONE is ignored.
- pkt_ack held high across DONE→IDLE releases only one packet. The next packet still requires a fresh DONE.
- rst mid-packet: all state returns to IDLE in the next cycle. The partial packet is discarded; no further writes; pkt_ready=0. The next IDLE re-pulses ram_len_rst.
- No zero-length packets exist: every packet carries at least one tlast beat.
- Minimum packet turnaround: 1 beat packet = 1 IDLE cycle + 1 FILL cycle + 1 FLUSH cycle, then pkt_ready.

Decomposition:
- Shared package: state encoding enum (IDLE, FILL, FLUSH, DROP, DONE); capacity constant 2**PORT_ADDR_WIDTH as a function of the parameter.
- One natural sub-module, axis_word_pairer: hold register plus even/odd tracking, producing {ram_addr, ram_di, ram_wr_en}.
- The FSM, counter and handshake stay in the top.

Test Plan:
- Stream 4 beats A,B,C,D (D tlast) -> ram_len_rst pulse, then writes {A,B}@0 and {C,D}@2. pkt_ready=1, pkt_words=4, pkt_overflow=0.
- Stream 3 beats A,B,C (C tlast) -> writes {A,B}@0 and FLUSH {C,0}@2; pkt_words=3.
- PORT_ADDR_WIDTH=3: stream 8 beats -> last write @6, pkt_overflow=0. Then stream 11 beats -> writes @0,2,4,6 only; 3 beats drained with tready=1; pkt_words=8, pkt_overflow=1.
- Random tvalid gaps (50% duty) on a 6-beat packet -> identical writes to the gap-free run; no extra ram_wr_en pulses.
- Hold pkt_ack=0 for 20 cycles after DONE -> tready stays 0 and pkt_ready stays 1. Pulse ack -> pkt_ready=0 next cycle, then IDLE with ram_len_rst pulse, then tready=1.
- Assert rst after beat 3 of a 6-beat packet -> no further writes; outputs all 0. A following 2-beat packet writes to @0 with pkt_words=2.

Source files
------------

// File: rtl/axis_packet_writer_pkg.sv
// Shared definitions for the packet writer: FSM state encoding and the
// packet RAM capacity helper.
package axis_packet_writer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        DROP  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Number of 32-bit words the packet RAM holds for a given address width.
    function automatic int unsigned capacity_words(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/axis_word_pairer.sv
// Packs consecutive stream beats into one double-word RAM write.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   beat_i          a beat is being stored this cycle
//   data_i          beat payload
//   idx_i           word index of the beat (low bits of the word counter)
//   flush_i         emit the held beat alone, padded with zero
//   ram_addr_o      even word address of the write
//   ram_di_o        {word at addr, word at addr+1}
//   ram_wr_en_o     one-cycle write strobe
module axis_word_pairer #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            beat_i,
    input  logic [DW-1:0]   data_i,
    input  logic [AW-1:0]   idx_i,
    input  logic            flush_i,
    output logic [AW-1:0]   ram_addr_o,
    output logic [2*DW-1:0] ram_di_o,
    output logic            ram_wr_en_o
);

    logic [DW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2*DW-1:0] di_q, di_d;
    logic            wr_q, wr_d;

    always_comb begin
        hold_d = hold_q;
        wr_d   = 1'b0;
        addr_d = '0;
        di_d   = '0;
        if (beat_i) begin
            if (!idx_i[0]) begin
                hold_d = data_i;
            end else begin
                wr_d   = 1'b1;
                addr_d = {idx_i[AW-1:1], 1'b0};
                di_d   = {hold_q, data_i};
            end
        end
        // During flush the counter already points past the held beat, so
        // clearing its LSB lands on the held beat's even address.
        if (flush_i) begin
            wr_d   = 1'b1;
            addr_d = {idx_i[AW-1:1], 1'b0};
            di_d   = {hold_q, {DW{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            addr_q <= '0;
            di_q   <= '0;
            wr_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            addr_q <= addr_d;
            di_q   <= di_d;
            wr_q   <= wr_d;
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_di_o    = di_q;
    assign ram_wr_en_o = wr_q;

endmodule

// File: rtl/axis_packet_writer.sv
// Writes one AXI-Stream packet into the packet RAM as 64-bit pairs and hands
// the buffer to the filter core, stalling the stream until it is released.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  input stream
//   ram_addr, ram_di, ram_wr_en    RAM write port (even addresses only)
//   ram_len_rst                    clears the RAM length tracker per packet
//   pkt_ready, pkt_words, pkt_overflow, pkt_ack  buffer handoff
//
// state | meaning
// IDLE  | clear counter/overflow; length-tracker clear pulses next cycle
// FILL  | accept beats, write every second beat as a pair
// FLUSH | write the lone trailing beat with a zero upper slot
// DROP  | RAM full: swallow beats until tlast
// DONE  | buffer owned by filter core until pkt_ack
module axis_packet_writer
    import axis_packet_writer_pkg::*;
#(
    parameter int PORT_ADDR_WIDTH = 10,
    parameter int PORT_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORT_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [PORT_ADDR_WIDTH-1:0]   ram_addr,
    output logic [2*PORT_DATA_WIDTH-1:0] ram_di,
    output logic                         ram_wr_en,
    output logic                         ram_len_rst,
    output logic                         pkt_ready,
    output logic [PORT_ADDR_WIDTH:0]     pkt_words,
    output logic                         pkt_overflow,
    input  logic                         pkt_ack
);

    localparam int AW = PORT_ADDR_WIDTH;
    localparam logic [AW:0] CAP = (AW+1)'(capacity_words(AW));

    state_e      state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;

    logic        tready_q, tready_d;
    logic        len_rst_q, len_rst_d;
    logic        pkt_ready_q, pkt_ready_d;
    logic [AW:0] pkt_words_q, pkt_words_d;
    logic        pkt_ovf_q, pkt_ovf_d;

    logic hs;
    logic cap_hit;
    logic fill_beat;

    assign hs        = s_axis_tvalid & tready_q;
    assign cap_hit   = (cnt_q == CAP);
    assign fill_beat = (state_q == FILL) & hs & ~cap_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            tready_q    <= 1'b0;
            len_rst_q   <= 1'b0;
            pkt_ready_q <= 1'b0;
            pkt_words_q <= '0;
            pkt_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            tready_q    <= tready_d;
            len_rst_q   <= len_rst_d;
            pkt_ready_q <= pkt_ready_d;
            pkt_words_q <= pkt_words_d;
            pkt_ovf_q   <= pkt_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = FILL;
            end
            FILL: begin
                if (hs) begin
                    if (cap_hit) begin
                        ovf_d   = 1'b1;
                        state_d = s_axis_tlast ? DONE : DROP;
                    end else begin
                        cnt_d = cnt_q + (AW+1)'(1);
                        if (s_axis_tlast) begin
                            state_d = cnt_q[0] ? DONE : FLUSH;
                        end
                    end
                end
            end
            FLUSH: state_d = DONE;
            DROP: begin
                if (hs && s_axis_tlast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Only an ack seen while pkt_ready is visible releases the
                // buffer, so a held ack cannot skip a packet.
                if (pkt_ack && pkt_ready_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // tready follows the next state so it lines up with FILL/DROP cycles.
        tready_d    = (state_d == FILL) || (state_d == DROP);
        len_rst_d   = (state_q == IDLE);
        pkt_ready_d = (state_q == DONE) && !(pkt_ack && pkt_ready_q);
        pkt_words_d = '0;
        pkt_ovf_d   = 1'b0;
        if (pkt_ready_d) begin
            pkt_words_d = (cnt_q > CAP) ? CAP : cnt_q;
            pkt_ovf_d   = ovf_q;
        end
    end

    axis_word_pairer #(
        .AW(AW),
        .DW(PORT_DATA_WIDTH)
    ) u_pairer (
        .clk         (clk),
        .rst         (rst),
        .beat_i      (fill_beat),
        .data_i      (s_axis_tdata),
        .idx_i       (cnt_q[AW-1:0]),
        .flush_i     (state_q == FLUSH),
        .ram_addr_o  (ram_addr),
        .ram_di_o    (ram_di),
        .ram_wr_en_o (ram_wr_en)
    );

    assign s_axis_tready = tready_q;
    assign ram_len_rst   = len_rst_q;
    assign pkt_ready     = pkt_ready_q;
    assign pkt_words     = pkt_words_q;
    assign pkt_overflow  = pkt_ovf_q;

endmodule
